// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding request/ready handshake with a
// fixed response latency, word storage with byte strobes, and address-range
// rejection. Outputs are registered and are zero outside the ready pulse.
module dmem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned LATENCY   = 2            // legal 1..15, fits the 4-bit counter
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_valid,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  req_t             req_q;
  req_t             req_in;
  req_t             req_cur;
  logic             go_resp;
  logic             legal;
  logic             mem_we;
  logic [31:0]      word_off;
  logic [IDX_W-1:0] idx;

  logic [31:0] mem [MEM_WORDS];

  assign req_in = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};

  // With LATENCY=1 the edge that accepts the request is also the edge into
  // RESP, so the live inputs must be used there; otherwise the latched copy.
  assign req_cur = (state == IDLE) ? req_in : req_q;

  // Flag the clock edge that enters RESP: all side effects happen on it.
  always_comb begin
    go_resp = 1'b0;
    case (state)
      IDLE:    go_resp = dmem_valid && (LATENCY == 1);
      WAIT:    go_resp = (cnt == 4'd1);
      default: go_resp = 1'b0;
    endcase
  end

  // Word offset is computed on the full 32 bits; comparing the shifted offset
  // against MEM_WORDS avoids overflow of BASE_ADDR + 4*MEM_WORDS.
  always_comb begin
    word_off = (req_cur.addr - BASE_ADDR) >> 2;
    legal    = (req_cur.addr[1:0] == 2'b00) &&
               (req_cur.addr >= BASE_ADDR) &&
               (word_off < 32'(MEM_WORDS));
    idx      = word_off[IDX_W-1:0];
    // rst_n gate keeps a LATENCY=1 request presented during reset from writing.
    mem_we   = go_resp && legal && req_cur.we && rst_n;
  end

  // Storage: byte-strobed write, no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_cur.wstrb[b]) mem[idx][8*b +: 8] <= req_cur.wdata[8*b +: 8];
      end
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_q      <= '0;
      dmem_ready <= 1'b0;
      dmem_error <= 1'b0;
      dmem_rdata <= 32'd0;
    end else begin
      dmem_ready <= 1'b0;
      dmem_error <= 1'b0;
      dmem_rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (dmem_valid) begin
            req_q <= req_in;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          // valid is not looked at here: a dropped request still completes
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        dmem_ready <= 1'b1;
        dmem_error <= !legal;
        dmem_rdata <= (legal && !req_cur.we) ? mem[idx] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a vector table on a LATENCY=2 instance plus hand sequences
// for back-to-back, reset-in-WAIT, LATENCY=1 and LATENCY=3 behaviour.
module tb_dmem_responder;

  logic clk;
  logic rst_n;

  // LATENCY=2, 1024 words
  logic        a_valid, a_we, a_ready, a_error;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_wstrb;
  // LATENCY=1, 16 words
  logic        b_valid, b_we, b_ready, b_error;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_wstrb;
  // LATENCY=3, 64 words
  logic        c_valid, c_we, c_ready, c_error;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_wstrb;

  int n_chk = 0;
  int n_err = 0;

  dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h1000_0000), .LATENCY(2)) u_a (
    .clk(clk), .rst_n(rst_n), .dmem_valid(a_valid), .dmem_we(a_we), .dmem_addr(a_addr),
    .dmem_wdata(a_wdata), .dmem_wstrb(a_wstrb), .dmem_rdata(a_rdata),
    .dmem_ready(a_ready), .dmem_error(a_error));

  dmem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h1000_0000), .LATENCY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .dmem_valid(b_valid), .dmem_we(b_we), .dmem_addr(b_addr),
    .dmem_wdata(b_wdata), .dmem_wstrb(b_wstrb), .dmem_rdata(b_rdata),
    .dmem_ready(b_ready), .dmem_error(b_error));

  dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h1000_0000), .LATENCY(3)) u_c (
    .clk(clk), .rst_n(rst_n), .dmem_valid(c_valid), .dmem_we(c_we), .dmem_addr(c_addr),
    .dmem_wdata(c_wdata), .dmem_wstrb(c_wstrb), .dmem_rdata(c_rdata),
    .dmem_ready(c_ready), .dmem_error(c_error));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // One request on instance A; fields are scrambled once accepted so the
  // response must come from the latched copy.
  task automatic run_a(input vec_t v, input int n);
    string s;
    s = $sformatf("vec%0d", n);
    @(negedge clk);
    a_valid = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_wstrb = v.wstrb;
    @(negedge clk);
    chk({s, " ready T+1"}, {31'd0, a_ready}, 32'd0);
    a_we = ~v.we; a_addr = 32'h1000_0004; a_wdata = ~v.wdata; a_wstrb = ~v.wstrb;
    @(negedge clk);
    chk({s, " ready T+2"}, {31'd0, a_ready}, 32'd1);
    chk({s, " error"}, {31'd0, a_error}, {31'd0, v.err});
    chk({s, " rdata"}, a_rdata, v.rdata);
    a_valid = 1'b0;
    @(negedge clk);
    chk({s, " ready T+3"}, {31'd0, a_ready}, 32'd0);
    chk({s, " idle err/rdata"}, {a_rdata[30:0], a_error}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h1000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 32'h1000_0010, 32'h0000_AA00, 4'h2, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 32'h1000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_AAEF};
    vt[4]  = '{1'b0, 32'h1000_0002, 32'h0,         4'h0, 1'b1, 32'h0};
    vt[5]  = '{1'b0, 32'h1000_1000, 32'h0,         4'h0, 1'b1, 32'h0};
    vt[6]  = '{1'b1, 32'h1000_0000, 32'h1122_3344, 4'hF, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 32'h1000_0002, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 32'h1000_1000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vt[9]  = '{1'b0, 32'h1000_0000, 32'h0,         4'h0, 1'b0, 32'h1122_3344};
    vt[10] = '{1'b1, 32'h1000_0000, 32'hAA00_00BB, 4'h9, 1'b0, 32'h0};
    vt[11] = '{1'b0, 32'h1000_0000, 32'h0,         4'h0, 1'b0, 32'hAA22_33BB};
    vt[12] = '{1'b1, 32'h0FFF_FFFC, 32'h0,         4'hF, 1'b1, 32'h0};
    vt[13] = '{1'b1, 32'h1000_0FFC, 32'hAABB_CCDD, 4'hF, 1'b0, 32'h0};
    vt[14] = '{1'b0, 32'h1000_0FFC, 32'h0,         4'h0, 1'b0, 32'hAABB_CCDD};
    vt[15] = '{1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0};
    vt[16] = '{1'b0, 32'h1000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_AAEF};
    vt[17] = '{1'b0, 32'h1000_0010, 32'h1234_5678, 4'hF, 1'b0, 32'hDEAD_AAEF};
    vt[18] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0};

    rst_n = 1'b0;
    a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_wstrb = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_wstrb = 0;
    c_valid = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_wstrb = 0;
    repeat (2) @(negedge clk);
    chk("rst a", {a_rdata[30:0], a_error} | {31'd0, a_ready}, 32'd0);
    chk("rst b", {b_rdata[30:0], b_error} | {31'd0, b_ready}, 32'd0);
    chk("rst c", {c_rdata[30:0], c_error} | {31'd0, c_ready}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) run_a(vt[i], i);

    // Three reads with valid held: pulses at T+2, T+5, T+8.
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 32'h1000_0010; a_wstrb = 4'h0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("b2b ready T+%0d", k), {31'd0, a_ready}, {31'd0, (k == 2 || k == 5 || k == 8)});
      if (k == 2) begin chk("b2b rdata0", a_rdata, 32'hDEAD_AAEF); a_addr = 32'h1000_0000; end
      if (k == 5) begin chk("b2b rdata1", a_rdata, 32'hAA22_33BB); a_addr = 32'h1000_0FFC; end
      if (k == 8) begin chk("b2b rdata2", a_rdata, 32'hAABB_CCDD); a_valid = 1'b0; end
    end

    // Reset pulse during WAIT of a write discards it.
    run_a('{1'b1, 32'h1000_0020, 32'h5555_5555, 4'hF, 1'b0, 32'h0}, 100);
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h1000_0020; a_wdata = 32'hCAFE_F00D; a_wstrb = 4'hF;
    @(negedge clk);
    chk("rstwait ready T+1", {31'd0, a_ready}, 32'd0);
    rst_n = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    chk("rstwait ready T+2", {31'd0, a_ready}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstwait no pulse", {31'd0, a_ready}, 32'd0);
    end
    run_a('{1'b0, 32'h1000_0020, 32'h0, 4'h0, 1'b0, 32'h5555_5555}, 101);

    // LATENCY=1: write, then valid held through RESP gives a read at T+3.
    @(negedge clk);
    b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h1000_0004; b_wdata = 32'h0BAD_CAFE; b_wstrb = 4'hF;
    @(negedge clk);
    chk("L1 wr ready T+1", {31'd0, b_ready}, 32'd1);
    chk("L1 wr error", {31'd0, b_error}, 32'd0);
    b_we = 1'b0;
    @(negedge clk);
    chk("L1 ready T+2", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    chk("L1 rd ready T+3", {31'd0, b_ready}, 32'd1);
    chk("L1 rd rdata", b_rdata, 32'h0BAD_CAFE);
    b_addr = 32'h1000_0040;
    @(negedge clk);
    chk("L1 ready T+4", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    chk("L1 oob ready", {31'd0, b_ready}, 32'd1);
    chk("L1 oob error", {31'd0, b_error}, 32'd1);
    chk("L1 oob rdata", b_rdata, 32'd0);
    b_valid = 1'b0;
    @(negedge clk);
    chk("L1 ready after", {31'd0, b_ready}, 32'd0);

    // LATENCY=3: write, then read whose valid drops in WAIT.
    @(negedge clk);
    c_valid = 1'b1; c_we = 1'b1; c_addr = 32'h1000_0008; c_wdata = 32'h0102_0304; c_wstrb = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("L3 wr ready T+%0d", k), {31'd0, c_ready}, {31'd0, (k == 3)});
      if (k == 3) c_valid = 1'b0;
    end
    @(negedge clk);
    c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h1000_0008;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("L3 rd ready T+%0d", k), {31'd0, c_ready}, {31'd0, (k == 3)});
      if (k == 1) begin c_valid = 1'b0; c_addr = 32'h1000_0002; c_we = 1'b1; end
      if (k == 3) chk("L3 rd rdata", c_rdata, 32'h0102_0304);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words of internal storage.
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h1000_0000: byte address of word 0.
REQ-003 The module SHALL have parameter LATENCY, default 2, legal range 1..15: cycles from request acceptance to the ready pulse.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port dmem_valid, input, 1: CPU request valid; held with its fields until dmem_ready is seen.
REQ-007 Port dmem_we, input, 1: 1 = write, 0 = read.
REQ-008 Port dmem_addr, input, 32: byte address.
REQ-009 Port dmem_wdata, input, 32: write data.
REQ-010 Port dmem_wstrb, input, 4: byte enables; bit i enables wdata[8i+7:8i].
REQ-011 Port dmem_rdata, output, 32: read data, valid only while dmem_ready=1.
REQ-012 Port dmem_ready, output, 1: one-cycle completion pulse; the CPU pipeline stalls while valid && !ready.
REQ-013 Port dmem_error, output, 1: qualifies dmem_ready; 1 = request rejected.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 In IDLE, a cycle T with dmem_valid=1 SHALL accept the request:
- latch we, addr, wdata and wstrb;
- load the latency counter;
- move to WAIT, or directly to RESP when LATENCY=1.
REQ-016 WAIT SHALL decrement the counter each cycle and move to RESP so that dmem_ready is high in cycle T+LATENCY exactly.
REQ-017 RESP SHALL last one cycle with dmem_ready=1, then return to IDLE unconditionally.
REQ-018 dmem_ready SHALL be a registered output, 0 in IDLE and WAIT.
REQ-019 An address SHALL be legal when all of the following hold:
- addr[1:0] = 0;
- addr >= BASE_ADDR;
- addr < BASE_ADDR + 4*MEM_WORDS.
Word index = (addr - BASE_ADDR) >> 2, using 32-bit unsigned arithmetic with no wrap.
REQ-020 Legal write: on the edge entering RESP, only the strobed bytes of the indexed word SHALL be updated; dmem_rdata = 0 during RESP.
REQ-021 Legal read: dmem_rdata SHALL equal the indexed word as sampled on the edge entering RESP; wstrb is ignored.
REQ-022 Illegal address: dmem_error=1 and dmem_rdata=0 during RESP; no storage update.
REQ-023 dmem_error and dmem_rdata SHALL be 0 whenever dmem_ready=0.
REQ-024 Back-to-back requests: dmem_valid held high into the cycle after RESP SHALL be treated as a new request accepted in that IDLE cycle. Minimum request spacing is therefore LATENCY+1 cycles.
REQ-025 Deassertion of dmem_valid during WAIT (protocol violation) SHALL NOT abort the transaction: the latched request completes and the ready pulse is still issued.
REQ-026 Changes to request fields after acceptance SHALL be ignored; only the latched values are used.
REQ-027 A write with wstrb=4'b0000 to a legal address SHALL complete normally with no storage change.

Reset
REQ-028 rst_n=0 SHALL asynchronously force:
- state = IDLE;
- counter = 0;
- dmem_ready = 0, dmem_error = 0, dmem_rdata = 0.
REQ-029 Reset asserted during WAIT or RESP SHALL discard the transaction: no write, no ready pulse after release.
REQ-030 Storage contents SHALL NOT be initialized by reset.
REQ-031 The first request SHALL be accepted in the first cycle after release in which dmem_valid=1.

Verification
REQ-032 LATENCY=2. Write addr=0x1000_0010, wdata=0xDEAD_BEEF, wstrb=4'hF at cycle T -> ready=1, error=0 at T+2 only. Then read the same address -> rdata=0xDEAD_BEEF with ready.
REQ-033 Partial write wstrb=4'b0010, wdata=0x0000_AA00 over 0xDEAD_BEEF -> subsequent read returns 0xDEAD_AAEF.
REQ-034 Read addr=0x1000_0002 (misaligned) and read addr=0x1000_1000 (one past end, MEM_WORDS=1024) -> each gives ready with error=1, rdata=0; no storage changes.
REQ-035 dmem_valid held high for three consecutive reads -> ready pulses at T+2, T+5 and T+8; each pulse exactly one cycle wide.
REQ-036 rst_n pulsed low during WAIT of a write to 0x1000_0020 -> no ready pulse, word unchanged; next request completes normally after LATENCY cycles.
REQ-037 LATENCY=1 build: single read accepted at T -> ready at T+1; then dmem_valid dropped in WAIT under LATENCY=3 -> ready still pulses at T+3.
